// File: rtl/ab_pkg.sv
// Shared definitions for the pulse-width measurement block.
package ab_pkg;

  localparam logic [1:0] ARM  = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  typedef enum logic [1:0] {
    StArm  = ARM,
    StIdle = IDLE,
    StMeas = MEAS,
    StOver = OVER
  } ab_state_e;

endpackage

// File: rtl/ab_sync.sv
// Multi-flop synchronizer bringing pulse_in into the clk domain.
module ab_sync #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s
);

  logic [SYNC-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[SYNC-2:0], d};
  end

  assign s = chain_q[SYNC-1];

endmodule

// File: rtl/ab_pwmeas.sv
// Measures the high time of an asynchronous pulse in clk cycles, with
// short/long rejection and one-cycle result strobes.
module ab_pwmeas
  import ab_pkg::*;
#(
  parameter int unsigned CW    = 7,
  parameter int unsigned MIN_W = 1,
  parameter int unsigned MAX_W = 127,
  parameter int unsigned SYNC  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse_in,
  output logic [CW-1:0] width,
  output logic          valid,
  output logic          err_short,
  output logic          err_long,
  output logic          busy
);

  localparam logic [CW-1:0] MinW = CW'(MIN_W);
  localparam logic [CW-1:0] MaxW = CW'(MAX_W);
  localparam int unsigned   AW   = $clog2(SYNC + 1);
  localparam logic [AW-1:0] Flushed = AW'(SYNC);

  logic          s, s_q, rise, fall;
  logic [AW-1:0] arm_cnt_q;
  ab_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, width_q, width_d;
  logic          valid_q, valid_d, err_short_q, err_short_d, err_long_q, err_long_d;

  ab_sync #(
    .SYNC(SYNC)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pulse_in),
    .s    (s)
  );

  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  // The chain's reset zeros are not a real low level; only leave ARM once
  // s carries a sample taken after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      s_q <= s;
      if (arm_cnt_q != Flushed) arm_cnt_q <= arm_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StArm;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArm:  if (arm_cnt_q == Flushed && !s) state_d = StIdle;
      StIdle: if (rise) state_d = StMeas;
      StMeas: begin
        if (fall)                     state_d = StIdle;
        else if (s && cnt_q == MaxW)  state_d = StOver;
      end
      StOver: if (fall) state_d = StIdle;
      default: state_d = StArm;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    width_d     = width_q;
    valid_d     = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    unique case (state_q)
      StIdle: if (rise) cnt_d = CW'(1);
      StMeas: begin
        if (fall) begin
          if (cnt_q >= MinW) begin
            valid_d = 1'b1;
            width_d = cnt_q;
          end else begin
            err_short_d = 1'b1;
          end
        end else if (s) begin
          if (cnt_q == MaxW) err_long_d = 1'b1;
          else               cnt_d      = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      width_q     <= '0;
      valid_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      valid_q     <= valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign width     = width_q;
  assign valid     = valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign busy      = (state_q == StMeas) || (state_q == StOver);

endmodule
